// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle IF/ID/EX/MEM/WB control FSM for the 31-instruction MIPS core
// Define MULTICYCLE_ILLEGAL_TRAP_EN to trap on illegal instructions instead of retiring them as NOPs.
module multicycle_ctrl #(
  parameter int CNT_W   = 32,
  parameter int MEM_TMO = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_oh,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             ir_we,
  output logic             mem_re,
  output logic             mem_we,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_sel,
  output logic             alu_src_b,
  output logic [4:0]       alu_sel,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             trap
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd7
  } state_t;

  localparam int WAIT_W = (MEM_TMO > 1) ? $clog2(MEM_TMO + 1) : 1;
  localparam logic [WAIT_W:0] TMO_LIM = (WAIT_W + 1)'(MEM_TMO);

  state_t            cur_state, nxt_state;
  // j never reaches EX/MEM/WB, so its bit is dropped: cls[29] is jal
  logic [29:0]       cls;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W:0]   wait_inc;
  logic [4:0]        oh_idx;
  logic              legal, retire, tmo_hit;
  logic              pc_we_raw, ir_we_raw, mem_re_raw, mem_we_raw, reg_we_raw;

  assign legal    = (instr_oh != 32'd0) && ((instr_oh & (instr_oh - 32'd1)) == 32'd0) && !instr_oh[31];
  assign wait_inc = {1'b0, wait_cnt} + {{WAIT_W{1'b0}}, 1'b1};
  assign tmo_hit  = (MEM_TMO != 0) && !mem_ready && (wait_inc == TMO_LIM);

  always_comb begin
    oh_idx = 5'd0;
    for (int i = 31; i >= 0; i--)
      if (instr_oh[i]) oh_idx = 5'(i);
  end

  always_comb begin
    nxt_state  = cur_state;
    pc_we_raw  = 1'b0;
    ir_we_raw  = 1'b0;
    mem_re_raw = 1'b0;
    mem_we_raw = 1'b0;
    reg_we_raw = 1'b0;
    pc_src     = 2'd0;
    reg_dst    = 2'd0;
    wb_sel     = 2'd0;
    alu_src_b  = 1'b0;
    retire     = 1'b0;
    case (cur_state)
      S_IF: begin
        mem_re_raw = 1'b1;
        if (mem_ready) begin
          ir_we_raw = 1'b1;
          pc_we_raw = 1'b1;
          nxt_state = S_ID;
        end else if (tmo_hit) begin
          nxt_state = S_TRAP;
        end
      end
      S_ID: begin
        if (!legal) begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          nxt_state = S_TRAP;
`else
          retire    = 1'b1;
          nxt_state = S_IF;
`endif
        end else if (instr_oh[29]) begin
          pc_we_raw = 1'b1;
          pc_src    = 2'd2;
          retire    = 1'b1;
          nxt_state = S_IF;
        end else if (instr_oh[30]) begin
          pc_we_raw = 1'b1;
          pc_src    = 2'd2;
          nxt_state = S_WB;
        end else begin
          nxt_state = S_EX;
        end
      end
      S_EX: begin
        alu_src_b = |cls[28:17];
        if (cls[16]) begin
          pc_we_raw = 1'b1;
          pc_src    = 2'd3;
          retire    = 1'b1;
          nxt_state = S_IF;
        end else if (cls[24] || cls[25]) begin
          pc_we_raw = cls[24] ? alu_zero : !alu_zero;
          pc_src    = 2'd1;
          retire    = 1'b1;
          nxt_state = S_IF;
        end else if (cls[22] || cls[23]) begin
          nxt_state = S_MEM;
        end else begin
          nxt_state = S_WB;
        end
      end
      S_MEM: begin
        mem_re_raw = cls[22];
        mem_we_raw = cls[23];
        if (mem_ready) begin
          if (cls[22]) begin
            nxt_state = S_WB;
          end else begin
            retire    = 1'b1;
            nxt_state = S_IF;
          end
        end else if (tmo_hit) begin
          nxt_state = S_TRAP;
        end
      end
      S_WB: begin
        reg_we_raw = 1'b1;
        retire     = 1'b1;
        nxt_state  = S_IF;
        if (cls[29]) begin
          reg_dst = 2'd2;
          wb_sel  = 2'd2;
        end else if (cls[22]) begin
          wb_sel = 2'd1;
        end else if (|cls[15:0]) begin
          reg_dst = 2'd1;
        end
      end
      S_TRAP: begin
        nxt_state = S_TRAP;
      end
      default: nxt_state = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_IF;
      cls       <= '0;
      alu_sel   <= '0;
      retired   <= '0;
      wait_cnt  <= '0;
      trap      <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == S_ID) begin
        cls     <= {instr_oh[30], instr_oh[28:0]};
        alu_sel <= oh_idx;
      end
      if (retire)
        retired <= retired + CNT_W'(1);
      if (nxt_state != cur_state)
        wait_cnt <= '0;
      else if ((cur_state == S_IF || cur_state == S_MEM) && !mem_ready)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (nxt_state == S_TRAP)
        trap <= 1'b1;
    end
  end

  // Strobes are suppressed during reset so an aborted instruction has no side effects
  assign pc_we  = pc_we_raw  && !rst;
  assign ir_we  = ir_we_raw  && !rst;
  assign mem_re = mem_re_raw && !rst;
  assign mem_we = mem_we_raw && !rst;
  assign reg_we = reg_we_raw && !rst;
  assign state  = cur_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
// Honours MULTICYCLE_ILLEGAL_TRAP_EN for the illegal-instruction expectations.
module tb_multicycle_ctrl;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_oh;
  logic        alu_zero, mem_ready;
  logic        pc_we, ir_we, mem_re, mem_we, reg_we, alu_src_b, trap;
  logic [1:0]  pc_src, reg_dst, wb_sel;
  logic [4:0]  alu_sel;
  logic [2:0]  state;
  logic [31:0] retired;

  int          checks = 0;
  int          errors = 0;
  int unsigned exp_ret = 0;

  multicycle_ctrl #(.CNT_W(32), .MEM_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .instr_oh(instr_oh), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .mem_re(mem_re), .mem_we(mem_we),
    .reg_we(reg_we), .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_src_b(alu_src_b),
    .alu_sel(alu_sel), .state(state), .retired(retired), .trap(trap)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] strobes();
    return {pc_we, ir_we, mem_re, mem_we, reg_we};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b1; instr_oh = 32'h1;
    #3;
    check("rst strobes", strobes(), 0);
    next_cycle();
    rst = 1'b0;
    exp_ret = 0;
    check("rst state", state, 0);
    check("rst trap", trap, 0);
    check("rst retired", retired, 0);
    check("rst alu_sel", alu_sel, 0);
  endtask

  task automatic expect_trap(input string tag);
    for (int c = 0; c < 3; c++) begin
      mem_ready = 1'($urandom);
      instr_oh  = $urandom;
      #3;
      check({tag, " trap state"}, state, 7);
      check({tag, " trap flag"}, trap, 1);
      check({tag, " trap strobes"}, strobes(), 0);
      next_cycle();
    end
    do_reset();
  endtask

  // Walks one instruction through the phases it should visit, checking each cycle.
  task automatic run_instr(input logic [31:0] oh, input int if_wait, input int mem_wait, input bit zero);
    int idx;
    bit legal, lw, sw, jal;
    legal = ($countones(oh) == 1) && !oh[31];
    idx = 0;
    for (int i = 31; i >= 0; i--) if (oh[i]) idx = i;
    lw  = legal && idx == 22;
    sw  = legal && idx == 23;
    jal = legal && idx == 30;
    instr_oh = oh;
    alu_zero = zero;
    for (int k = 0; k <= if_wait; k++) begin
      if (k == TMO) begin expect_trap("IF tmo"); return; end
      mem_ready = (k == if_wait);
      #3;
      if (k == 0) check("retired", retired, exp_ret);
      check("IF state", state, 0);
      check("IF strobes", strobes(), {mem_ready, mem_ready, 1'b1, 2'b00});
      if (mem_ready) check("IF pc_src", pc_src, 0);
      next_cycle();
    end
    mem_ready = 1'($urandom);
    #3;
    check("ID state", state, 1);
    if (!legal) begin
      check("ID illegal strobes", strobes(), 0);
      next_cycle();
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      expect_trap("illegal");
`else
      exp_ret++;
`endif
      return;
    end
    if (idx == 29 || idx == 30) begin
      check("ID jump strobes", strobes(), 5'b10000);
      check("ID pc_src", pc_src, 2);
      next_cycle();
      if (idx == 29) begin exp_ret++; return; end
    end else begin
      check("ID strobes", strobes(), 0);
      next_cycle();
      #3;
      check("EX state", state, 2);
      check("EX alu_sel", alu_sel, idx);
      check("EX alu_src_b", alu_src_b, (idx >= 17 && idx <= 28));
      if (idx == 16) begin
        check("EX jr strobes", strobes(), 5'b10000);
        check("EX jr pc_src", pc_src, 3);
        next_cycle(); exp_ret++; return;
      end
      if (idx == 24 || idx == 25) begin
        check("EX br strobes", strobes(), {((idx == 24) ? zero : !zero), 4'b0000});
        check("EX br pc_src", pc_src, 1);
        next_cycle(); exp_ret++; return;
      end
      check("EX strobes", strobes(), 0);
      next_cycle();
      if (lw || sw) begin
        for (int k = 0; k <= mem_wait; k++) begin
          if (k == TMO) begin expect_trap("MEM tmo"); return; end
          mem_ready = (k == mem_wait);
          #3;
          check("MEM state", state, 3);
          check("MEM strobes", strobes(), {2'b00, lw, sw, 1'b0});
          next_cycle();
        end
        if (sw) begin exp_ret++; return; end
      end
    end
    mem_ready = 1'($urandom);
    #3;
    check("WB state", state, 4);
    check("WB strobes", strobes(), 5'b00001);
    check("WB reg_dst", reg_dst, jal ? 2 : (lw ? 0 : ((idx <= 15) ? 1 : 0)));
    check("WB wb_sel", wb_sel, jal ? 2 : (lw ? 1 : 0));
    next_cycle();
    exp_ret++;
  endtask

  initial begin
    rst = 1'b1; instr_oh = '0; alu_zero = 1'b0; mem_ready = 1'b0;
    next_cycle();
    do_reset();

    run_instr(32'h1 << 1, 0, 0, 1'b0);
    check("addu retired", retired, 1);
    run_instr(32'h1 << 22, 0, 3, 1'b0);
    run_instr(32'h1 << 24, 0, 0, 1'b1);
    run_instr(32'h1 << 24, 0, 0, 1'b0);
    run_instr(32'h1 << 30, 1, 0, 1'b0);
    run_instr(32'h0, 0, 0, 1'b0);
    run_instr(32'h1 << 5, 0, 0, 1'b0);

    // reset during a taken beq in EX must suppress pc_we and the retire
    instr_oh = 32'h1 << 24; alu_zero = 1'b1; mem_ready = 1'b1;
    next_cycle();
    next_cycle();
    do_reset();

    for (int n = 0; n < 150; n++) begin
      logic [31:0] oh;
      int iw, mw;
      case ($urandom_range(0, 15))
        0:       oh = 32'h0;
        1:       oh = (32'h1 << $urandom_range(0, 30)) | 32'h8000_0000;
        2:       oh = 32'h3 << $urandom_range(0, 29);
        3:       oh = 32'h8000_0000;
        4, 5, 6: oh = 32'h1 << (22 + $urandom_range(0, 1));
        default: oh = 32'h1 << $urandom_range(0, 30);
      endcase
      iw = ($urandom_range(0, 15) == 0) ? TMO : $urandom_range(0, TMO - 1);
      mw = ($urandom_range(0, 7) == 0) ? TMO : $urandom_range(0, TMO - 1);
      run_instr(oh, iw, mw, 1'($urandom));
    end

    run_instr(32'h1 << 3, 10, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
